// File: rtl/if_fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package if_fetch_pkg;

  typedef logic [31:0] inst_t;
  typedef logic [31:0] inst_addr_t;

  localparam inst_t ZERO_WORD    = 32'h0000_0000;
  localparam logic  NO_STOP      = 1'b0;
  localparam logic  RST_ENABLE_N = 1'b0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_VALID,
    S_KILL
  } fetch_state_e;

  function automatic inst_addr_t align_word(input inst_addr_t addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_fetch_if.sv
// Instruction-memory fetch bus: ce is held until the single rvalid pulse answers it.
interface if_fetch_if;
  import if_fetch_pkg::*;

  logic       ce;
  inst_addr_t addr;
  logic       rvalid;
  inst_t      rdata;

  modport master (output ce, output addr, input rvalid, input rdata);
  modport slave  (input ce, input addr, output rvalid, output rdata);

endinterface

// File: rtl/if_fetch.sv
// IF stage: owns the PC, keeps one fetch outstanding and presents {if_pc, if_inst} to IF/ID.
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter inst_addr_t  RESET_PC = 32'h0000_0000,
  parameter int unsigned PC_STEP  = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [5:0]  stall,
  input  logic        branch_flag,
  input  inst_addr_t  branch_target,
  if_fetch_if.master  imem,
  output inst_addr_t  if_pc,
  output inst_t       if_inst,
  output logic        stallreq
);

  localparam inst_addr_t STEP = 32'(PC_STEP);

  fetch_state_e state;
  inst_addr_t   pc;
  inst_addr_t   buf_pc;
  inst_t        buf_inst;
  logic         accept;
  logic         unused_stall;

  assign accept       = (stall[0] == NO_STOP) && (stall[1] == NO_STOP);
  assign unused_stall = ^stall[5:2];

  // A redirect always wins; in S_KILL it only retargets pc, the stale response is still swallowed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (rst_n == RST_ENABLE_N) begin
      state    <= S_IDLE;
      pc       <= RESET_PC;
      buf_pc   <= ZERO_WORD;
      buf_inst <= ZERO_WORD;
    end else begin
      if (branch_flag) pc <= align_word(branch_target);
      case (state)
        S_IDLE: begin
          if (!branch_flag) state <= S_FETCH;
        end
        S_FETCH: begin
          if (imem.rvalid) begin
            if (!branch_flag) begin
              buf_inst <= imem.rdata;
              buf_pc   <= pc;
              state    <= S_VALID;
            end
          end else if (branch_flag) begin
            state <= S_KILL;
          end
        end
        S_VALID: begin
          if (branch_flag) begin
            state <= S_FETCH;
          end else if (accept) begin
            pc    <= pc + STEP;
            state <= S_FETCH;
          end
        end
        S_KILL: begin
          if (imem.rvalid) state <= S_FETCH;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    imem.ce   = 1'b0;
    imem.addr = ZERO_WORD;
    if_pc     = ZERO_WORD;
    if_inst   = ZERO_WORD;
    stallreq  = 1'b0;
    case (state)
      S_FETCH: begin
        imem.ce   = 1'b1;
        imem.addr = pc;
        stallreq  = !imem.rvalid;
      end
      S_VALID: begin
        if_pc   = buf_pc;
        if_inst = buf_inst;
      end
      S_KILL:  stallreq = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: bench-side memory with variable latency plus a program-flow scoreboard.
module tb_if_fetch;
  import if_fetch_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [5:0]  stall;
  logic        branch_flag;
  logic [31:0] branch_target;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        stallreq;

  if_fetch_if bus();

  if_fetch #(.RESET_PC(RST_PC), .PC_STEP(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall         (stall),
    .branch_flag   (branch_flag),
    .branch_target (branch_target),
    .imem          (bus),
    .if_pc         (if_pc),
    .if_inst       (if_inst),
    .stallreq      (stallreq)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int failures = 0;

  // memory model state
  logic        mem_busy = 1'b0;
  int          mem_cnt = 0;
  logic [31:0] req_addr = '0;
  int          lat = 1;
  logic        lat_rand = 1'b0;
  logic        ce_s = 1'b0;
  logic [31:0] addr_s = '0;

  // scoreboard state
  logic [31:0] exp_pc = RST_PC;
  logic        prev_valid = 1'b0;
  logic        prev_consumed = 1'b0;
  logic [31:0] prev_pc = '0;
  logic [31:0] prev_inst = '0;
  int          idle = 0;
  int          n_instr = 0;

  logic        obs_ce;
  logic [31:0] obs_addr;
  logic [31:0] obs_pc;
  logic [31:0] obs_inst;
  logic        obs_sr;

  // Memory contents are a pure function of the address and never zero for aligned addresses.
  function automatic logic [31:0] memWord(input logic [31:0] a);
    return ~a ^ 32'h3C00_0000;
  endfunction

  function automatic logic [31:0] b32(input logic b);
    return {31'b0, b};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic memStep();
    if (bus.rvalid) begin
      bus.rvalid = 1'b0;
      mem_busy   = 1'b0;
    end else if (mem_busy) begin
      mem_cnt--;
      if (mem_cnt == 0) bus.rvalid = 1'b1;
    end else if (ce_s) begin
      mem_busy = 1'b1;
      req_addr = addr_s;
      mem_cnt  = lat_rand ? int'($urandom_range(1, 4)) : lat;
      mem_cnt--;
      if (mem_cnt == 0) bus.rvalid = 1'b1;
    end
    bus.rdata = bus.rvalid ? memWord(req_addr) : $urandom;
  endtask

  task automatic applyStimulus(input logic [5:0] st, input logic br, input logic [31:0] tgt);
    stall         = st;
    branch_flag   = br;
    branch_target = tgt;
  endtask

  task automatic finishCycle();
    logic valid;
    logic accepted;
    logic exp_sr;
    #1;
    obs_ce   = bus.ce;
    obs_addr = bus.addr;
    obs_pc   = if_pc;
    obs_inst = if_inst;
    obs_sr   = stallreq;
    if (!rst_n) begin
      checkOutput("rst_ce", b32(obs_ce), 32'd0);
      checkOutput("rst_pc", obs_pc, 32'd0);
      checkOutput("rst_inst", obs_inst, 32'd0);
      checkOutput("rst_stallreq", b32(obs_sr), 32'd0);
      exp_pc        = RST_PC;
      prev_valid    = 1'b0;
      prev_consumed = 1'b0;
      idle          = 0;
    end else begin
      valid  = (obs_inst != 32'd0);
      exp_sr = obs_ce ? !bus.rvalid : (mem_busy && !valid);
      checkOutput("stallreq", b32(obs_sr), b32(exp_sr));
      if (obs_ce) checkOutput("fetch_addr", obs_addr, exp_pc);
      if (obs_ce && mem_busy) checkOutput("addr_held", obs_addr, req_addr);
      if (!valid) checkOutput("bubble_pc", obs_pc, 32'd0);
      if (prev_valid && !prev_consumed) begin
        checkOutput("held_valid", b32(valid), 32'd1);
        checkOutput("hold_pc", obs_pc, prev_pc);
        checkOutput("hold_inst", obs_inst, prev_inst);
      end else if (valid) begin
        checkOutput("new_pc", obs_pc, exp_pc);
        checkOutput("new_inst", obs_inst, memWord(obs_pc));
        n_instr++;
      end
      if (valid) begin
        idle = 0;
      end else begin
        idle++;
        if (idle > 40) begin
          checkOutput("liveness", idle, 32'd0);
          idle = 0;
        end
      end
      accepted = valid && (stall[1:0] == 2'b00) && !branch_flag;
      if (branch_flag) exp_pc = {branch_target[31:2], 2'b00};
      else if (accepted) exp_pc = obs_pc + 32'd4;
      prev_consumed = valid && (branch_flag || accepted);
      prev_valid    = valid;
      prev_pc       = obs_pc;
      prev_inst     = obs_inst;
    end
    ce_s   = obs_ce;
    addr_s = obs_addr;
    @(posedge clk);
    #1;
  endtask

  task automatic cycle(input logic [5:0] st, input logic br, input logic [31:0] tgt);
    memStep();
    applyStimulus(st, br, tgt);
    finishCycle();
  endtask

  task automatic runUntilValid(input logic [5:0] st, input string tag);
    logic got;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      cycle(st, 1'b0, 32'd0);
      got = (obs_inst != 32'd0);
    end
    checkOutput(tag, b32(got), 32'd1);
  endtask

  initial begin
    logic [31:0] fetch_q[$];
    logic        pce;
    logic        found;
    logic [31:0] held_pc;
    logic [31:0] held_inst;
    logic [31:0] first_addr;
    logic        have_first;
    int          sr_cnt;
    logic [31:0] inst_at_rvalid;
    logic        saw_late;
    logic        ce_k[10];

    rst_n = 1'b0;
    applyStimulus(6'b0, 1'b0, 32'd0);
    bus.rvalid = 1'b0;
    bus.rdata  = '0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) cycle(6'b0, 1'b0, 32'd0);

    // 1: one-cycle memory, sequential fetch from RESET_PC
    lat = 1;
    rst_n = 1'b1;
    fetch_q.delete();
    for (int k = 0; k < 10; k++) begin
      pce = ce_s;
      cycle(6'b0, 1'b0, 32'd0);
      ce_k[k] = obs_ce;
      if (k == 3) begin
        checkOutput("t1_first_pc", obs_pc, RST_PC);
        checkOutput("t1_first_inst", obs_inst, memWord(RST_PC));
      end
      if (obs_ce && !pce) fetch_q.push_back(obs_addr);
    end
    checkOutput("t1_ce_idle", b32(ce_k[0]), 32'd0);
    checkOutput("t1_ce_first", b32(ce_k[1]), 32'd1);
    checkOutput("t1_fetch_count", b32(fetch_q.size() >= 3), 32'd1);
    if (fetch_q.size() >= 3) begin
      checkOutput("t1_addr0", fetch_q[0], RST_PC);
      checkOutput("t1_addr1", fetch_q[1], RST_PC + 32'd4);
      checkOutput("t1_addr2", fetch_q[2], RST_PC + 32'd8);
    end

    // 2: three-cycle memory, stallreq high for exactly three cycles
    lat = 3;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      pce = ce_s;
      cycle(6'b0, 1'b0, 32'd0);
      found = obs_ce && !pce;
    end
    checkOutput("t2_fetch_start", b32(found), 32'd1);
    sr_cnt = int'(obs_sr);
    inst_at_rvalid = 32'hDEAD_BEEF;
    for (int i = 0; i < 20 && obs_inst == 32'd0; i++) begin
      memStep();
      applyStimulus(6'b0, 1'b0, 32'd0);
      finishCycle();
      if (bus.rvalid === 1'b0 && obs_inst == 32'd0 && inst_at_rvalid == 32'hDEAD_BEEF) ;
      if (obs_ce && obs_sr == 1'b0) inst_at_rvalid = obs_inst;
      sr_cnt += int'(obs_sr);
    end
    checkOutput("t2_stall_cycles", sr_cnt, 32'd3);
    checkOutput("t2_inst_at_rvalid", inst_at_rvalid, 32'd0);

    // 3: hold in S_VALID under stall, then advance
    lat = 1;
    runUntilValid(6'b000011, "t3_wait_valid");
    held_pc   = obs_pc;
    held_inst = obs_inst;
    for (int i = 0; i < 4; i++) begin
      cycle(6'b000011, 1'b0, 32'd0);
      checkOutput("t3_no_ce", b32(obs_ce), 32'd0);
      checkOutput("t3_pc_stable", obs_pc, held_pc);
      checkOutput("t3_inst_stable", obs_inst, held_inst);
    end
    cycle(6'b0, 1'b0, 32'd0);
    cycle(6'b0, 1'b0, 32'd0);
    checkOutput("t3_ce_after", b32(obs_ce), 32'd1);
    checkOutput("t3_addr_after", obs_addr, held_pc + 32'd4);

    // 4: redirect while the fetch at 0x8 is outstanding
    lat = 3;
    cycle(6'b0, 1'b1, 32'h0000_0008);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      cycle(6'b0, 1'b0, 32'd0);
      found = obs_ce && (obs_addr == 32'h8);
    end
    checkOutput("t4_fetch8", b32(found), 32'd1);
    memStep();
    checkOutput("t4_outstanding", {30'b0, bus.rvalid, mem_busy}, 32'd1);
    applyStimulus(6'b0, 1'b1, 32'h0000_0100);
    finishCycle();
    cycle(6'b0, 1'b0, 32'd0);
    checkOutput("t4_kill_ce", b32(obs_ce), 32'd0);
    checkOutput("t4_kill_stallreq", b32(obs_sr), 32'd1);
    have_first = 1'b0;
    first_addr = '0;
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      cycle(6'b0, 1'b0, 32'd0);
      if (obs_ce && !have_first) begin
        have_first = 1'b1;
        first_addr = obs_addr;
      end
      found = (obs_inst != 32'd0);
    end
    checkOutput("t4_first_addr", first_addr, 32'h0000_0100);
    checkOutput("t4_pc", obs_pc, 32'h0000_0100);
    checkOutput("t4_inst", obs_inst, memWord(32'h0000_0100));

    // 5: unaligned redirect coincident with rvalid
    lat = 1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      memStep();
      found = bus.rvalid;
      applyStimulus(6'b0, found, 32'h0000_0203);
      finishCycle();
    end
    checkOutput("t5_rvalid_seen", b32(found), 32'd1);
    cycle(6'b0, 1'b0, 32'd0);
    checkOutput("t5_ce", b32(obs_ce), 32'd1);
    checkOutput("t5_addr", obs_addr, 32'h0000_0200);
    runUntilValid(6'b0, "t5_wait_valid");
    checkOutput("t5_pc", obs_pc, 32'h0000_0200);

    // PC wrap-around at the top of the address space
    cycle(6'b0, 1'b1, 32'hFFFF_FFFF);
    runUntilValid(6'b0, "wrap_wait_top");
    checkOutput("wrap_top_pc", obs_pc, 32'hFFFF_FFFC);
    runUntilValid(6'b0, "wrap_wait_zero");
    checkOutput("wrap_zero_pc", obs_pc, 32'h0000_0000);
    checkOutput("wrap_zero_inst", obs_inst, memWord(32'h0));

    // 6: asynchronous reset in the middle of a fetch
    lat = 3;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      cycle(6'b0, 1'b0, 32'd0);
      found = obs_ce && mem_busy;
    end
    checkOutput("t6_outstanding", b32(found), 32'd1);
    memStep();
    applyStimulus(6'b0, 1'b0, 32'd0);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("t6_async_ce", b32(bus.ce), 32'd0);
    checkOutput("t6_async_addr", bus.addr, 32'd0);
    checkOutput("t6_async_stallreq", b32(stallreq), 32'd0);
    finishCycle();
    saw_late = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cycle(6'b0, 1'b0, 32'd0);
      if (bus.rvalid) saw_late = 1'b1;
    end
    checkOutput("t6_late_rvalid", b32(saw_late), 32'd1);
    rst_n = 1'b1;
    cycle(6'b0, 1'b0, 32'd0);
    checkOutput("t6_idle_ce", b32(obs_ce), 32'd0);
    cycle(6'b0, 1'b0, 32'd0);
    checkOutput("t6_refetch_ce", b32(obs_ce), 32'd1);
    checkOutput("t6_refetch_addr", obs_addr, RST_PC);
    runUntilValid(6'b0, "t6_wait_valid");
    checkOutput("t6_pc", obs_pc, RST_PC);

    // randomized traffic: latency 1..4, random stalls and redirects
    lat_rand = 1'b1;
    n_instr  = 0;
    for (int i = 0; i < 600; i++) begin
      logic [5:0]  st;
      logic        br;
      logic [31:0] tgt;
      st  = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'b0;
      br  = ($urandom_range(0, 11) == 0);
      tgt = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 + 32'($urandom_range(0, 7)) : $urandom;
      cycle(st, br, tgt);
    end
    checkOutput("random_progress", b32(n_instr > 20), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
